// File: rtl/decoder_scan_seq.sv
// Scan sequencer driving a 3-to-8 decoder: blank gap, then timed or
// stepped show of each index, wrapping after the programmed last index.
module decoder_scan_seq #(
  parameter int BLANK_CYCLES = 2,
  parameter int DWELL_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               step,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [2:0]         last,
  output logic               dec_en,
  output logic [2:0]         dec_in,
  output logic               busy,
  output logic               wrap
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BLANK = 2'd1;
  localparam logic [1:0] S_SHOW  = 2'd2;

  localparam logic [7:0] BLANK_LD = 8'(BLANK_CYCLES - 1);

  logic [1:0]         state, state_n;
  logic [7:0]         bcnt, bcnt_n;
  logic [DWELL_W-1:0] dcnt, dcnt_n;
  logic               man, man_n;
  logic [2:0]         idx_n;
  logic [2:0]         idx_inc;
  logic               wrap_n;
  logic               leave;

  // An index above a freshly lowered last also wraps to 0.
  assign idx_inc = (dec_in >= last) ? 3'd0 : dec_in + 3'd1;
  assign leave   = man ? step : (dcnt == '0);

  always_comb begin
    state_n = state;
    bcnt_n  = bcnt;
    dcnt_n  = dcnt;
    man_n   = man;
    idx_n   = dec_in;
    wrap_n  = 1'b0;
    if (stop) begin
      state_n = S_IDLE;
    end else begin
      unique case (1'b1)
        state == S_IDLE: begin
          if (start) begin
            state_n = S_BLANK;
            idx_n   = 3'd0;
            bcnt_n  = BLANK_LD;
          end
        end
        state == S_BLANK: begin
          if (bcnt == 8'd0) begin
            state_n = S_SHOW;
            man_n   = mode;
            dcnt_n  = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
          end else begin
            bcnt_n = bcnt - 8'd1;
          end
        end
        state == S_SHOW: begin
          if (leave) begin
            state_n = S_BLANK;
            idx_n   = idx_inc;
            wrap_n  = (idx_inc == 3'd0);
            bcnt_n  = BLANK_LD;
          end else if (!man) begin
            dcnt_n = dcnt - DWELL_W'(1);
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      bcnt   <= 8'd0;
      dcnt   <= '0;
      man    <= 1'b0;
      dec_in <= 3'd0;
      dec_en <= 1'b0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      state  <= state_n;
      bcnt   <= bcnt_n;
      dcnt   <= dcnt_n;
      man    <= man_n;
      dec_in <= idx_n;
      dec_en <= (state_n == S_SHOW);
      busy   <= (state_n != S_IDLE);
      wrap   <= wrap_n;
    end
  end

endmodule

// File: tb/tb_decoder_scan_seq.sv
// Bench for decoder_scan_seq: phase/remaining-cycle model checked every
// cycle, plus hand-computed cycle expectations from the scan timing.
module tb_decoder_scan_seq;

  localparam int B = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        mode  = 1'b0;
  logic        step  = 1'b0;
  logic [15:0] dwell = 16'd3;
  logic [2:0]  last  = 3'd7;
  logic        dec_en;
  logic [2:0]  dec_in;
  logic        busy;
  logic        wrap;

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  decoder_scan_seq #(
    .BLANK_CYCLES(B),
    .DWELL_W(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .mode(mode),
    .step(step),
    .dwell(dwell),
    .last(last),
    .dec_en(dec_en),
    .dec_in(dec_in),
    .busy(busy),
    .wrap(wrap)
  );

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  // Model: scanning or not, showing or blanking, cycles left in phase.
  bit m_busy, m_show, m_manual, m_wrap;
  int m_left, m_idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_show = 0; m_manual = 0; m_wrap = 0;
      m_left = 0; m_idx = 0;
    end else begin
      m_wrap = 0;
      if (stop) begin
        m_busy = 0;
        m_show = 0;
      end else if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_show = 0; m_left = B; m_idx = 0;
        end
      end else if (!m_show) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_show   = 1;
          m_manual = mode;
          m_left   = (dwell == 0) ? 1 : int'(dwell);
        end
      end else begin
        bit done;
        if (m_manual) done = step;
        else begin
          m_left = m_left - 1;
          done = (m_left == 0);
        end
        if (done) begin
          m_idx  = (m_idx >= int'(last)) ? 0 : m_idx + 1;
          m_wrap = (m_idx == 0);
          m_show = 0;
          m_left = B;
        end
      end
    end
  end

  logic       p_en = 1'b0;
  logic [2:0] p_in = 3'd0;

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("dec_en", dec_en, m_busy && m_show);
      chk("dec_in", dec_in, m_idx);
      chk("busy", busy, m_busy);
      chk("wrap", wrap, m_wrap);
      if (p_en && dec_en) chk("dec_in_stable", dec_in, p_in);
      p_en = dec_en;
      p_in = dec_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic halt();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_dec_en", dec_en, 0);
    chk("rst_dec_in", dec_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    cmp_on = 1'b1;

    // Auto scan B=2 D=3 last=7; after go() we are in cycle 1.
    mode = 0; dwell = 16'd3; last = 3'd7;
    go();
    for (int k = 1; k <= 45; k++) begin
      if (k > 1) tick();
      if (k == 1) chk("a_busy1", busy, 1);
      if (k == 2) chk("a_en2", dec_en, 0);
      if (k == 3) chk("a_en3", dec_en, 1);
      if (k == 3) chk("a_in3", dec_in, 0);
      if (k == 5) chk("a_en5", dec_en, 1);
      if (k == 6) chk("a_en6", dec_en, 0);
      if (k == 6) chk("a_in6", dec_in, 1);
      if (k == 8) chk("a_en8", dec_en, 1);
      if (k == 38) chk("a_in38", dec_in, 7);
      if (k == 40) chk("a_en40", dec_en, 1);
      if (k == 41) chk("a_wrap41", wrap, 1);
      if (k == 41) chk("a_in41", dec_in, 0);
      if (k == 42) chk("a_wrap42", wrap, 0);
      if (k == 43) chk("a_en43", dec_en, 1);
      if (k == 43) chk("a_in43", dec_in, 0);
    end
    halt();
    chk("a_stop_busy", busy, 0);

    // dwell=0 => 1-cycle show, last=2, step toggling ignored in auto.
    dwell = 16'd0; last = 3'd2;
    go();
    for (int k = 1; k <= 30; k++) begin
      if (k > 1) tick();
      step = k[0];
      if (k == 3) chk("d0_en3", dec_en, 1);
      if (k == 4) chk("d0_en4", dec_en, 0);
      if (k == 4) chk("d0_in4", dec_in, 1);
      if (k == 10) chk("d0_wrap10", wrap, 1);
    end
    step = 0;
    halt();

    // last=0: index stays 0, wrap every period.
    dwell = 16'd2; last = 3'd0;
    go();
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) tick();
      if (k == 5) chk("l0_wrap5", wrap, 1);
      if (k == 9) chk("l0_wrap9", wrap, 1);
    end
    halt();

    // Manual mode.
    mode = 1; dwell = 16'd3; last = 3'd7;
    go();
    pulse_step();
    repeat (4) tick();
    pulse_step();
    repeat (7) tick();
    pulse_step();
    repeat (2) tick();
    pulse_step();
    repeat (3) tick();
    mode = 0;
    repeat (1000) tick();
    chk("m_hold_en", dec_en, 1);
    chk("m_hold_in", dec_in, 3);
    pulse_step();
    chk("m_adv_en", dec_en, 0);
    chk("m_adv_in", dec_in, 4);
    repeat (5) tick();
    halt();
    mode = 0;

    // Stop in IDLE, start+stop in IDLE, stop in BLANK, stop+step in SHOW.
    halt();
    chk("s_idle_busy", busy, 0);
    start = 1; stop = 1;
    tick();
    start = 0; stop = 0;
    chk("s_both_busy", busy, 0);
    tick();
    chk("s_both_busy2", busy, 0);
    go();
    halt();
    chk("s_blank_busy", busy, 0);
    chk("s_blank_en", dec_en, 0);
    dwell = 16'd3; last = 3'd7;
    go();
    repeat (7) tick();
    chk("s_show_pre", dec_en, 1);
    step = 1;
    halt();
    step = 0;
    chk("s_show_en", dec_en, 0);
    chk("s_show_busy", busy, 0);
    chk("s_show_in", dec_in, 1);
    go();
    chk("s_restart_in", dec_in, 0);
    halt();

    // last lowered to 3 while showing index 5; dwell change mid-show.
    dwell = 16'd3; last = 3'd7;
    go();
    for (int k = 1; k <= 50; k++) begin
      if (k > 1) tick();
      if (k == 29) begin
        chk("lr_in29", dec_in, 5);
        last = 3'd3;
      end
      if (k == 31) chk("lr_in31", dec_in, 0);
      if (k == 31) chk("lr_wrap31", wrap, 1);
      if (k == 34) dwell = 16'd5;
      if (k == 35) chk("dw_en35", dec_en, 1);
      if (k == 36) chk("dw_en36", dec_en, 0);
      if (k == 42) chk("dw_en42", dec_en, 1);
      if (k == 42) chk("dw_in42", dec_in, 1);
      if (k == 43) chk("dw_en43", dec_en, 0);
    end

    // Async reset mid-show, between clock edges.
    halt();
    dwell = 16'd3; last = 3'd7;
    go();
    repeat (8) tick();
    chk("r_pre_en", dec_en, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("r_en", dec_en, 0);
    chk("r_in", dec_in, 0);
    chk("r_busy", busy, 0);
    chk("r_wrap", wrap, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick();
    chk("r_idle_busy", busy, 0);
    go();
    chk("r_restart_busy", busy, 1);
    repeat (10) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decoder_scan_seq.md
# decoder_scan_seq

Scan sequencer that generates the enable and 3-bit select feeding the 3-to-8 one-hot decoder, stepping through the eight decoder outputs in turn. It is used for multiplexed digit/LED scanning. Each index is shown for a programmable dwell time, and a blanking gap separates consecutive indices so the select only changes while the decoder is disabled. Auto-scan and manual single-step modes are supported.

## Interface
- BLANK_CYCLES, 2, decoder-disabled cycles between consecutive indices; legal range 1..255.
- DWELL_W, 16, width of the dwell input.

- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  level-sampled; from IDLE begins a scan at index 0.
- stop  in  1  level-sampled; returns to IDLE from any state.
- mode  in  1  0 = auto (dwell-timed advance), 1 = manual (advance on step).
- step  in  1  single-cycle pulse; advances the index in manual mode only.
- dwell  in  DWELL_W  SHOW length in cycles for auto mode; 0 is treated as 1.
- last  in  3  highest index scanned; the index wraps to 0 after it.
- dec_en  out  1  decoder enable; high only in SHOW.
- dec_in  out  3  decoder select (current index).
- busy  out  1  high whenever the state is not IDLE.
- wrap  out  1  one-cycle pulse when the index wraps to 0.

## Operation
- States: IDLE, BLANK, SHOW. All outputs are registered.
- Reset: state=IDLE, dec_en=0, dec_in=0, busy=0, wrap=0, counters=0.
- IDLE: dec_en=0. When start=1 and stop=0: index<=0, blank counter loaded, go to BLANK.
- BLANK: dec_en=0 for exactly BLANK_CYCLES cycles, then go to SHOW.
  - On entry to SHOW, latch mode and dwell. Latched dwell = max(dwell,1).
- SHOW, auto: dec_en=1 for exactly the latched dwell cycles.
- SHOW, manual: dec_en=1 until step=1 is sampled.
- Leaving SHOW: advance the index, then go to BLANK.
  - Next index = 0 if index >= last, else index+1.
  - wrap pulses in the first BLANK cycle when the next index is 0.
- Index handling: the index (dec_in) changes only on the SHOW->BLANK transition, never while dec_en=1.
- Ignored inputs: step is ignored in IDLE, in BLANK, and in auto-mode SHOW. start is ignored when not in IDLE.
- stop: from any state, go to IDLE next cycle. dec_en=0 and busy=0 from that cycle. dec_in holds its value. No wrap pulse.
- stop and start both high in IDLE: stop wins, stay in IDLE.
- stop and step in the same SHOW cycle: stop wins, the index is not advanced.
- last changed mid-scan: takes effect at the next advance. If the index is already above the new last, the next index is 0.
- dwell and mode changes during SHOW have no effect until the next SHOW entry.
- last=0: index stays 0 and wrap pulses on every advance.
- Reset mid-operation: outputs return immediately (asynchronously) to their reset values.

## Timing
- start sampled at edge t:
  - busy=1 from t+1.
  - dec_en=0 for cycles t+1..t+B (B = BLANK_CYCLES).
  - dec_en=1 with dec_in=0 for cycles t+B+1..t+B+D (D = latched dwell).
- Steady auto scan: period per index = B + D cycles; dec_en duty = D/(B+D).
- Manual: step sampled at edge s during SHOW → dec_en=0 and dec_in=next from s+1; the next SHOW begins at s+B+1.
- stop sampled at edge t → dec_en=0 and busy=0 from t+1.
- wrap is high for exactly one cycle, coincident with the first BLANK cycle after the advance to 0.
- Maximum dwell = 2^DWELL_W − 1 cycles; the counter must not overflow.

## Test plan
- Auto scan, B=2, dwell=3, last=7: start at cycle 0.
  - dec_en high cycles 3–5 (dec_in=0), 8–10 (dec_in=1), …, 38–40 (dec_in=7).
  - wrap=1 at cycle 41, then dec_in=0 shown at 43–45.
- Dwell/last edge values: dwell=0 gives a 1-cycle SHOW. last=2 cycles 0,1,2,0, with wrap each lap. last=0 stays at 0 and pulses wrap every period.
- Manual mode: step pulses at arbitrary spacing advance exactly one index each, with B blank cycles between. step during BLANK or in auto mode does not advance. Holding in SHOW for 1000 cycles with no step keeps dec_en=1.
- stop in each state (IDLE, BLANK, SHOW): next cycle dec_en=0 and busy=0, dec_in held. Then start restarts at index 0. Simultaneous start+stop in IDLE stays in IDLE.
- last reduced from 7 to 3 while index=5: next index is 0 with wrap=1. dwell changed mid-SHOW: the current SHOW length is unchanged and the next SHOW uses the new value.
- Asynchronous rst_n pulse mid-SHOW, between clock edges: dec_en, dec_in, busy and wrap go to 0 immediately. After release, the block stays in IDLE until start.
- Checker on every test: dec_in never changes while dec_en=1.
